// File: rtl/mux_n_1_scan.sv
// mux_n_1_scan -- parametrised N:1 registered multiplexer with manual and scan modes.
//
// One input channel is selected and registered on each in_valid cycle.
// In MANUAL mode the channel comes from s. In SCAN mode an internal counter
// steps through channels 0..CHANNELS-1, advancing once per sample.
// There is one clock of latency.
//
// Optional feature: define MUX_PARITY_EN to add the y_par output. y_par is
// the even parity of y (^y) and is registered together with y.
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   mode      0 = MANUAL, 1 = SCAN
//   s         channel select, used in MANUAL mode only
//   d         packed channels; channel k = d[k*WIDTH +: WIDTH]
//   in_valid  sample strobe
//   y         registered selected data
//   y_valid   high for one cycle after each in_valid cycle
//   y_ch      index of the channel that produced y
//   y_err     the MANUAL select was >= CHANNELS
//   y_par     even parity of y (only with MUX_PARITY_EN)
//
// Mode FSM
//   state     | meaning
//   ST_MANUAL | channel index taken from s; scan counter frozen
//   ST_SCAN   | channel index taken from scan counter
module mux_n_1_scan #(
   parameter int WIDTH    = 3,
   parameter int CHANNELS = 8,
   localparam int SEL_W   = $clog2(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      mode,
   input  logic [SEL_W-1:0]          s,
   input  logic [CHANNELS*WIDTH-1:0] d,
   input  logic                      in_valid,
   output logic [WIDTH-1:0]          y,
   output logic                      y_valid,
   output logic [SEL_W-1:0]          y_ch,
`ifdef MUX_PARITY_EN
   output logic                      y_err,
   output logic                      y_par
`else
   output logic                      y_err
`endif
);

   localparam logic [SEL_W:0]   CH_LIM  = (SEL_W+1)'(CHANNELS);
   localparam logic [SEL_W-1:0] CH_LAST = SEL_W'(CHANNELS - 1);

   typedef enum logic {
      ST_MANUAL = 1'b0,
      ST_SCAN   = 1'b1
   } state_t;

   state_t             state_q;
   state_t             state_d;
   logic [SEL_W-1:0]   scan_cnt;
   logic [SEL_W-1:0]   scan_cnt_d;
   logic [SEL_W-1:0]   idx;
   logic               idx_bad;
   logic               scan_entry;
   logic [WIDTH-1:0]   sel_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_MANUAL;
         scan_cnt <= '0;
      end else begin
         state_q  <= state_d;
         scan_cnt <= scan_cnt_d;
      end
   end

   // The live mode input decides the current cycle, so a sample taken on
   // the mode-change cycle already uses the new mode.
   always_comb begin
      state_d    = mode ? ST_SCAN : ST_MANUAL;
      scan_entry = (state_d == ST_SCAN) && (state_q == ST_MANUAL);
      idx        = s;
      idx_bad    = 1'b0;
      scan_cnt_d = scan_cnt;

      if (state_d == ST_SCAN) begin
         // On the entry cycle the counter is treated as already cleared.
         idx = scan_entry ? '0 : scan_cnt;
         if (scan_entry) scan_cnt_d = '0;
         if (in_valid) scan_cnt_d = (idx == CH_LAST) ? '0 : idx + 1'b1;
      end else begin
         idx_bad = ({1'b0, s} >= CH_LIM);
      end
   end

   // Out-of-range indices match no channel, so the selected data is zero.
   always_comb begin
      sel_data = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         if (idx == SEL_W'(k)) sel_data = d[k*WIDTH +: WIDTH];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y       <= '0;
         y_valid <= 1'b0;
         y_ch    <= '0;
         y_err   <= 1'b0;
      end else begin
         y_valid <= in_valid;
         if (in_valid) begin
            y     <= sel_data;
            y_ch  <= idx;
            y_err <= idx_bad;
         end
      end
   end

`ifdef MUX_PARITY_EN
   // sel_data is already zero on an error, so the parity is zero as well.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_par <= 1'b0;
      end else if (in_valid) begin
         y_par <= ^sel_data;
      end
   end
`endif

endmodule

// File: tb/tb_mux_n_1_scan.sv
module tb_mux_n_1_scan;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        mode = 1'b0;
   logic [2:0]  s = '0;
   logic [23:0] dvec = '0;
   logic        in_valid = 1'b0;

   logic [2:0]  y8, y6;
   logic        v8, v6;
   logic [2:0]  ch8, ch6;
   logic        err8, err6;
`ifdef MUX_PARITY_EN
   logic        par8, par6;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mux_n_1_scan u8 (
      .clk(clk), .rst_n(rst_n), .mode(mode), .s(s), .d(dvec), .in_valid(in_valid),
      .y(y8), .y_valid(v8), .y_ch(ch8),
`ifdef MUX_PARITY_EN
      .y_err(err8), .y_par(par8)
`else
      .y_err(err8)
`endif
   );

   mux_n_1_scan #(.WIDTH(3), .CHANNELS(6)) u6 (
      .clk(clk), .rst_n(rst_n), .mode(mode), .s(s), .d(dvec[17:0]), .in_valid(in_valid),
      .y(y6), .y_valid(v6), .y_ch(ch6),
`ifdef MUX_PARITY_EN
      .y_err(err6), .y_par(par6)
`else
      .y_err(err6)
`endif
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: index 0 is the 8-channel instance, index 1 the 6-channel one.
   int nch[2] = '{8, 6};
   int m_cnt[2];
   int m_prev[2];
   int e_y[2];
   int e_v[2];
   int e_ch[2];
   int e_err[2];

   function automatic int chan_val(input int k);
      return int'((dvec >> (3 * k)) & 24'h7);
   endfunction

   task automatic model_step(input int i);
      int ix;
      if (in_valid) begin
         if (mode) begin
            ix       = (m_prev[i] == 0) ? 0 : m_cnt[i];
            e_y[i]   = chan_val(ix);
            e_err[i] = 0;
            m_cnt[i] = (ix + 1) % nch[i];
         end else begin
            ix = int'(s);
            if (ix < nch[i]) begin
               e_y[i]   = chan_val(ix);
               e_err[i] = 0;
            end else begin
               e_y[i]   = 0;
               e_err[i] = 1;
            end
         end
         e_ch[i] = ix;
         e_v[i]  = 1;
      end else begin
         e_v[i] = 0;
         if (mode && m_prev[i] == 0) m_cnt[i] = 0;
      end
      m_prev[i] = mode ? 1 : 0;
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0; m_prev[i] = 0; e_y[i] = 0;
            e_v[i] = 0; e_ch[i] = 0; e_err[i] = 0;
         end
      end else begin
         for (int i = 0; i < 2; i++) model_step(i);
      end
   end

   function automatic int par3(input int v);
      logic [2:0] t;
      t = v[2:0];
      return int'(^t);
   endfunction

   always @(negedge clk) begin
      if (rst_n) begin
         chk("model y8", int'(y8), e_y[0]);
         chk("model y_valid8", int'(v8), e_v[0]);
         chk("model y_ch8", int'(ch8), e_ch[0]);
         chk("model y_err8", int'(err8), e_err[0]);
         chk("model y6", int'(y6), e_y[1]);
         chk("model y_valid6", int'(v6), e_v[1]);
         chk("model y_ch6", int'(ch6), e_ch[1]);
         chk("model y_err6", int'(err6), e_err[1]);
`ifdef MUX_PARITY_EN
         chk("model y_par8", int'(par8), par3(e_y[0]));
         chk("model y_par6", int'(par6), par3(e_y[1]));
`endif
      end
   end

   task automatic drive(input bit md, input int sv, input bit iv);
      mode     = md;
      s        = sv[2:0];
      in_valid = iv;
      @(negedge clk);
   endtask

   int exp_wrap[8] = '{0, 1, 2, 3, 4, 5, 0, 1};

   initial begin
      dvec = 24'o76543210;
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset y8", int'(y8), 0);
      chk("reset y_valid8", int'(v8), 0);
      chk("reset y_ch6", int'(ch6), 0);
      chk("reset y_err6", int'(err6), 0);
      rst_n = 1'b1;
      @(negedge clk);

      // MANUAL sweep, channel k carries value k
      for (int sv = 0; sv < 8; sv++) begin
         drive(0, sv, 1);
         chk("sweep y8", int'(y8), sv);
         chk("sweep y_ch8", int'(ch8), sv);
         chk("sweep y_valid8", int'(v8), 1);
         if (sv >= 5) begin
            chk("range y6", int'(y6), (sv == 5) ? 5 : 0);
            chk("range y_err6", int'(err6), (sv == 5) ? 0 : 1);
            chk("range y_valid6", int'(v6), 1);
            chk("range y_ch6", int'(ch6), sv);
         end
      end
      drive(0, 0, 0);
      chk("hold y8", int'(y8), 7);
      chk("hold y_valid8", int'(v8), 0);

      // SCAN wrap
      for (int n = 0; n < 8; n++) begin
         drive(1, 3, 1);
         chk("wrap y_ch6", int'(ch6), exp_wrap[n]);
         chk("wrap y_ch8", int'(ch8), n);
         chk("wrap y6", int'(y6), exp_wrap[n]);
      end

      // SCAN with gaps
      drive(0, 0, 0);
      drive(1, 0, 1);
      chk("gap1 y_ch6", int'(ch6), 0);
      chk("gap1 y_valid6", int'(v6), 1);
      drive(1, 0, 0);
      chk("gap2 y_ch6", int'(ch6), 0);
      chk("gap2 y_valid6", int'(v6), 0);
      drive(1, 0, 1);
      chk("gap3 y_ch6", int'(ch6), 1);
      chk("gap3 y_valid6", int'(v6), 1);

      // Mode switch: SCAN at 3 -> MANUAL s=7 -> SCAN restarts at 0
      drive(1, 0, 1);
      drive(1, 0, 1);
      chk("switch y_ch6 at 3", int'(ch6), 3);
      drive(0, 7, 1);
      chk("switch manual y_ch6", int'(ch6), 7);
      chk("switch manual y_err6", int'(err6), 1);
      drive(1, 0, 1);
      chk("switch rescan y_ch6", int'(ch6), 0);
      chk("switch rescan y_ch8", int'(ch8), 0);

      // SCAN entry without a sample still restarts at channel 0
      drive(1, 0, 1);
      drive(0, 2, 0);
      drive(1, 0, 0);
      drive(1, 0, 1);
      chk("quiet entry y_ch8", int'(ch8), 0);

`ifdef MUX_PARITY_EN
      dvec = 24'o00000073;
      drive(0, 0, 1);
      chk("parity 011", int'(par8), 0);
      drive(0, 1, 1);
      chk("parity 111", int'(par8), 1);
`endif

      // Mixed random traffic, checked by the model every cycle
      for (int n = 0; n < 80; n++) begin
         dvec = 24'($urandom());
         drive(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0, int'($urandom_range(0, 7)),
               ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0);
      end

      // Asynchronous reset mid-stream
      dvec = 24'o76543210;
      drive(0, 7, 1);
      chk("pre-reset y8", int'(y8), 7);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async y8", int'(y8), 0);
      chk("async y_valid8", int'(v8), 0);
      chk("async y_ch8", int'(ch8), 0);
      chk("async y_err6", int'(err6), 0);
      chk("async y_ch6", int'(ch6), 0);
      @(negedge clk);
      mode = 1'b1;
      rst_n = 1'b1;
      drive(1, 0, 1);
      drive(1, 0, 1);
      chk("post-reset y_ch8", int'(ch8), 1);
      chk("post-reset y8", int'(y8), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
